// File: rtl/drive_cmd_scheduler.sv
// Drive command scheduler: round-robin arbitration of remote/manual drive commands,
// periodic read_enable strobe generation and a bounded reverse-torque braking sequence.
module drive_cmd_scheduler #(
    parameter int TICK_CYCLES = 5000000,
    parameter int HOLD_TICKS  = 5,
    parameter int BRAKE_TICKS = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       req_remote,
    input  logic [1:0] remote_instr,
    input  logic [2:0] remote_torque,
    output logic       remote_ack,
    input  logic       req_manual,
    input  logic [1:0] manual_instr,
    input  logic [2:0] manual_torque,
    output logic       manual_ack,
    output logic [1:0] instruction,
    output logic [2:0] torque,
    output logic       read_enable,
    output logic       grant_src,
    output logic [1:0] state
);

    localparam int TW   = (TICK_CYCLES > 2) ? $clog2(TICK_CYCLES) : 1;
    localparam int CMAX = (HOLD_TICKS > BRAKE_TICKS) ? HOLD_TICKS : BRAKE_TICKS;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
    localparam logic [TW-1:0] TICK_PRE  = TW'(TICK_CYCLES - 2);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_TICKS);
    localparam logic [CW-1:0] BRAKE_LOAD = CW'(BRAKE_TICKS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_BRAKE = 2'b10
    } state_e;

    state_e        state_q, state_d;
    logic [1:0]    instr_q, instr_d;
    logic [2:0]    torque_q, torque_d;
    logic          read_en_q, read_en_d;
    logic          remote_ack_q, remote_ack_d;
    logic          manual_ack_q, manual_ack_d;
    logic          grant_src_q, grant_src_d;
    logic          prio_q, prio_d;      // 1: manual wins the next tie
    logic [TW-1:0] tick_q, tick_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic       remote_ok;
    logic       manual_ok;
    logic       pick_manual;
    logic [2:0] req_torque;

    // A source is not eligible again while its own ack is still visible.
    assign remote_ok   = req_remote && !remote_ack_q;
    assign manual_ok   = req_manual && !manual_ack_q;
    assign pick_manual = manual_ok && (!remote_ok || prio_q);
    assign req_torque  = pick_manual ? manual_torque : remote_torque;

    // NOTE: every _d gets a default first, so no path through this block can infer a latch.
    always_comb begin
        state_d      = state_q;
        instr_d      = instr_q;
        torque_d     = torque_q;
        read_en_d    = 1'b0;
        remote_ack_d = 1'b0;
        manual_ack_d = 1'b0;
        grant_src_d  = grant_src_q;
        prio_d       = prio_q;
        tick_d       = tick_q;
        cnt_d        = cnt_q;

        if (!enable) begin
            state_d  = ST_IDLE;
            instr_d  = 2'b00;
            torque_d = 3'd0;
            tick_d   = '0;
            cnt_d    = '0;
        end else if (remote_ok || manual_ok) begin
            // Accepting also suppresses any strobe due at this edge and restarts the tick.
            state_d      = ST_RUN;
            instr_d      = pick_manual ? manual_instr : remote_instr;
            torque_d     = (req_torque > 3'd4) ? 3'd4 : req_torque;
            grant_src_d  = pick_manual;
            prio_d       = !pick_manual;
            remote_ack_d = !pick_manual;
            manual_ack_d = pick_manual;
            tick_d       = '0;
            cnt_d        = HOLD_LOAD;
        end else if (state_q != ST_IDLE) begin
            if (tick_q == TICK_LAST) begin
                // The strobe is visible this cycle; phase changes land on the next one.
                tick_d = '0;
                if (cnt_q <= CW'(1)) begin
                    if (state_q == ST_RUN) begin
                        state_d  = ST_BRAKE;
                        instr_d  = 2'b01;
                        torque_d = 3'd1;
                        cnt_d    = BRAKE_LOAD;
                    end else begin
                        state_d  = ST_IDLE;
                        instr_d  = 2'b00;
                        torque_d = 3'd0;
                        cnt_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end else begin
                tick_d    = tick_q + 1'b1;
                read_en_d = (tick_q == TICK_PRE);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            instr_q      <= 2'b00;
            torque_q     <= 3'd0;
            read_en_q    <= 1'b0;
            remote_ack_q <= 1'b0;
            manual_ack_q <= 1'b0;
            grant_src_q  <= 1'b0;
            prio_q       <= 1'b0;
            tick_q       <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            instr_q      <= instr_d;
            torque_q     <= torque_d;
            read_en_q    <= read_en_d;
            remote_ack_q <= remote_ack_d;
            manual_ack_q <= manual_ack_d;
            grant_src_q  <= grant_src_d;
            prio_q       <= prio_d;
            tick_q       <= tick_d;
            cnt_q        <= cnt_d;
        end
    end

    assign remote_ack  = remote_ack_q;
    assign manual_ack  = manual_ack_q;
    assign instruction = instr_q;
    assign torque      = torque_q;
    assign read_enable = read_en_q;
    assign grant_src   = grant_src_q;
    assign state       = state_q;

endmodule

// File: tb/tb_drive_cmd_scheduler.sv
// Directed bench for drive_cmd_scheduler with TICK_CYCLES=4, HOLD_TICKS=2, BRAKE_TICKS=3.
module tb_drive_cmd_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       req_remote;
    logic [1:0] remote_instr;
    logic [2:0] remote_torque;
    logic       remote_ack;
    logic       req_manual;
    logic [1:0] manual_instr;
    logic [2:0] manual_torque;
    logic       manual_ack;
    logic [1:0] instruction;
    logic [2:0] torque;
    logic       read_enable;
    logic       grant_src;
    logic [1:0] state;

    int errors = 0;
    int checks = 0;

    drive_cmd_scheduler #(
        .TICK_CYCLES(4),
        .HOLD_TICKS (2),
        .BRAKE_TICKS(3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .req_remote   (req_remote),
        .remote_instr (remote_instr),
        .remote_torque(remote_torque),
        .remote_ack   (remote_ack),
        .req_manual   (req_manual),
        .manual_instr (manual_instr),
        .manual_torque(manual_torque),
        .manual_ack   (manual_ack),
        .instruction  (instruction),
        .torque       (torque),
        .read_enable  (read_enable),
        .grant_src    (grant_src),
        .state        (state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1;
        req_remote = 1'b0; remote_instr = 2'b00; remote_torque = 3'd0;
        req_manual = 1'b0; manual_instr = 2'b00; manual_torque = 3'd0;
        step(); step();
        reset = 1'b0;

        check("rst_state", state, 2'b00);
        check("rst_instr", instruction, 2'b00);
        check("rst_torque", torque, 3'd0);
        check("rst_re", read_enable, 1'b0);
        check("rst_acks", {remote_ack, manual_ack}, 2'b00);
        check("rst_grant", grant_src, 1'b0);

        // Full sequence: accept, two RUN strobes, three BRAKE strobes, IDLE.
        req_remote = 1'b1; remote_instr = 2'b00; remote_torque = 3'd3;
        step();
        check("t1_ack", remote_ack, 1'b1);
        check("t1_state", state, 2'b01);
        check("t1_instr", instruction, 2'b00);
        check("t1_torque", torque, 3'd3);
        check("t1_re_k1", read_enable, 1'b0);
        req_remote = 1'b0;
        for (int k = 2; k <= 21; k++) begin
            step();
            check("t1_re", read_enable, (k % 4 == 0) && (k <= 20));
            if (k == 2) check("t1_ack_drop", remote_ack, 1'b0);
            if (k == 8) check("t1_run_k8", {state, instruction, torque}, {2'b01, 2'b00, 3'd3});
            if (k == 9) check("t1_brake_k9", {state, instruction, torque}, {2'b10, 2'b01, 3'd1});
            if (k == 20) check("t1_brake_k20", state, 2'b10);
        end
        check("t1_idle", {state, instruction, torque}, {2'b00, 2'b00, 3'd0});
        for (int k = 0; k < 4; k++) begin
            step();
            check("t1_idle_re", read_enable, 1'b0);
        end

        // Round-robin from a fresh reset: remote first, then the held manual, then remote.
        reset = 1'b1; #1; reset = 1'b0;
        req_remote = 1'b1; remote_instr = 2'b10; remote_torque = 3'd2;
        req_manual = 1'b1; manual_instr = 2'b11; manual_torque = 3'd7;
        step();
        check("rr1_acks", {remote_ack, manual_ack}, 2'b10);
        check("rr1_grant", grant_src, 1'b0);
        check("rr1_cmd", {instruction, torque}, {2'b10, 3'd2});
        req_remote = 1'b0;
        step();
        check("rr2_acks", {remote_ack, manual_ack}, 2'b01);
        check("rr2_grant", grant_src, 1'b1);
        check("rr2_sat", {instruction, torque}, {2'b11, 3'd4});
        req_manual = 1'b0;
        step();
        check("rr2_ack_drop", {remote_ack, manual_ack}, 2'b00);
        req_remote = 1'b1; req_manual = 1'b1;
        step();
        check("rr3_acks", {remote_ack, manual_ack}, 2'b10);
        check("rr3_grant", grant_src, 1'b0);
        req_remote = 1'b0;
        step();
        check("rr4_acks", {remote_ack, manual_ack}, 2'b01);
        req_manual = 1'b0;
        step();

        // Refresh that coincides with the terminal count suppresses that strobe.
        req_remote = 1'b1; remote_instr = 2'b00; remote_torque = 3'd2;
        step();
        check("t3_ack", remote_ack, 1'b1);
        req_remote = 1'b0;
        step(); step();
        req_remote = 1'b1; remote_instr = 2'b10; remote_torque = 3'd3;
        step();
        check("t3_no_strobe", read_enable, 1'b0);
        check("t3_ack2", remote_ack, 1'b1);
        check("t3_cmd", {instruction, torque}, {2'b10, 3'd3});
        req_remote = 1'b0;
        for (int k = 2; k <= 13; k++) begin
            step();
            check("t3_re", read_enable, (k == 4) || (k == 8) || (k == 12));
            if (k == 8) check("t3_run_k8", state, 2'b01);
            if (k == 9) check("t3_brake_k9", state, 2'b10);
        end

        // Request during BRAKE after one brake strobe: straight back to RUN.
        req_manual = 1'b1; manual_instr = 2'b00; manual_torque = 3'd5;
        step();
        check("t4_ack", manual_ack, 1'b1);
        check("t4_run", {state, instruction, torque}, {2'b01, 2'b00, 3'd4});
        check("t4_grant", grant_src, 1'b1);
        req_manual = 1'b0;
        for (int k = 2; k <= 5; k++) begin
            step();
            check("t4_re", read_enable, k == 4);
            if (k == 4) check("t4_run_k4", state, 2'b01);
        end

        // enable low in RUN: IDLE next cycle, held request is not acknowledged.
        enable = 1'b0;
        req_remote = 1'b1; remote_instr = 2'b11; remote_torque = 3'd2;
        step();
        check("t5_idle", {state, instruction, torque}, {2'b00, 2'b00, 3'd0});
        check("t5_re", read_enable, 1'b0);
        check("t5_grant_hold", grant_src, 1'b1);
        for (int k = 0; k < 5; k++) begin
            step();
            check("t5_dis_ack_re", {remote_ack, read_enable}, 2'b00);
        end
        enable = 1'b1;
        step();
        check("t5_resume", {remote_ack, state, instruction, torque}, {1'b1, 2'b01, 2'b11, 3'd2});
        check("t5_resume_grant", grant_src, 1'b0);
        req_remote = 1'b0;
        step(); step(); step();
        check("t6_strobe", read_enable, 1'b1);

        // Asynchronous reset cuts the strobe short.
        #1 reset = 1'b1;
        #1;
        check("t6_rst_re", read_enable, 1'b0);
        check("t6_rst_state", state, 2'b00);
        #1 reset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/drive_cmd_scheduler.md
Name: drive_cmd_scheduler

Overview:
- Command controller in front of the wheel-speed/display datapath.
- Arbitrates drive commands from two requesters (IR remote decoder, manual switch/key panel) and latches the winner onto the datapath's instruction/torque inputs.
- Issues the periodic one-cycle read_enable strobe that advances wheel velocity.
- On command timeout, runs a bounded reverse-torque braking sequence before going idle.

Parameters:
TICK_CYCLES, 5000000, clk cycles between read_enable strobes (10 Hz at 50 MHz); minimum 2
HOLD_TICKS, 5, strobes a granted command stays active without a refresh
BRAKE_TICKS, 5, strobes spent braking after timeout (instruction 2'b01, torque 1)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  drive enable; low forces IDLE
req_remote  in  1  remote command request, held until ack
remote_instr  in  2  00 fwd, 01 back, 10 left, 11 right
remote_torque  in  3  requested torque 0..7
remote_ack  out  1  one-cycle pulse: remote command latched
req_manual  in  1  manual command request, held until ack
manual_instr  in  2  as remote_instr
manual_torque  in  3  as remote_torque
manual_ack  out  1  one-cycle pulse: manual command latched
instruction  out  2  to datapath
torque  out  3  to datapath, always 0..4
read_enable  out  1  one-cycle velocity-update strobe
grant_src  out  1  0 remote, 1 manual (last granted)
state  out  2  00 IDLE, 01 RUN, 10 BRAKE

Behaviour:
- Reset values:
  - state IDLE.
  - instruction 00, torque 0, read_enable 0.
  - acks 0, grant_src 0.
  - tick counter 0, tick count 0.
  - Round-robin pointer set so that remote wins the first tie.
- All outputs are registered.
- Acceptance:
  - Allowed in IDLE, RUN and BRAKE whenever enable=1 and at least one req is high.
  - When only one source requests, that source wins.
  - When both request, the source not granted last wins (round-robin).
  - The acceptance cycle latches instr/torque and updates grant_src.
  - The ack pulses the next cycle.
  - The requester must drop req on seeing ack.
  - The block does not re-accept the same source while its ack is high.
- Torque saturation: latched torque = min(req_torque, 4).
- Accept effects:
  - Enters RUN.
  - Tick counter reset to 0.
  - Hold counter loaded with HOLD_TICKS.
  - Accept in BRAKE aborts braking immediately.
- Strobe timing in RUN/BRAKE:
  - Tick counter counts 0..TICK_CYCLES-1.
  - At terminal count, read_enable=1 for exactly one cycle.
  - First strobe occurs TICK_CYCLES cycles after the accept cycle.
- Output stability: instruction/torque never change in the same cycle read_enable is high.
- Accept coinciding with tick terminal count: accept wins, counter restarts, no strobe that cycle.
- RUN:
  - Each strobe decrements the hold counter.
  - The strobe that takes the hold counter to 0 is still issued with the RUN command.
  - After that strobe: enter BRAKE, load BRAKE_TICKS, instruction 01, torque 1, tick counter restarts.
- BRAKE:
  - Each strobe decrements the count.
  - After the strobe that reaches 0: IDLE, instruction 00, torque 0.
- IDLE: no strobes; tick counter held at 0.
- enable=0 (synchronous, any state):
  - Next cycle: IDLE, outputs zeroed, counters cleared.
  - Requests ignored, no acks issued.
  - On return of enable, acceptance resumes normally.
- Asynchronous reset mid-strobe or mid-ack truncates the pulse immediately.
- grant_src holds its last value through BRAKE/IDLE.

Test Plan:
- TICK_CYCLES=4, HOLD_TICKS=2, BRAKE_TICKS=3. Remote req instr=00, torque=3 at cycle 0 -> remote_ack at cycle 1; state RUN, instruction 00, torque 3; read_enable at cycles 4 and 8; BRAKE from cycle 9 (instr 01, torque 1); strobes at 12, 16, 20; IDLE at 21 with torque 0.
- Both reqs high at the same cycle after reset -> remote granted first (grant_src 0). Manual held -> manual granted on its next request evaluation (grant_src 1). Next tie -> remote.
- Manual req torque=7 -> latched torque 4.
- Remote refresh arriving exactly on a terminal-count cycle -> no strobe that cycle; next strobe 4 cycles after accept; hold reloaded to 2.
- Request during BRAKE (after 1 brake strobe) -> immediate RUN with the new command; no further brake strobes.
- enable dropped in RUN -> next cycle IDLE, instruction 00, torque 0, no read_enable. Req held while enable=0 -> no ack. Assert reset during a read_enable pulse -> read_enable 0 immediately.
